// File: rtl/lbp_pkg.sv
// rtl/lbp_pkg.sv - shared constants, state encoding and address helpers for the LBP host memory
package lbp_pkg;

    localparam int IMG_W_DEF  = 128;
    localparam int IMG_H_DEF  = 128;
    localparam int EXP_WRITES = (IMG_W_DEF - 2) * (IMG_H_DEF - 2);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SERVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Row is the address shifted down by log2(width); column is the low bits.
    function automatic logic is_border(input logic [31:0] addr, input int w_log2, input int img_h);
        logic [31:0] col_mask;
        logic [31:0] row;
        logic [31:0] col;
        col_mask = (32'd1 << w_log2) - 32'd1;
        col      = addr & col_mask;
        row      = addr >> w_log2;
        return (row == 32'd0) || (row == 32'(img_h - 1)) || (col == 32'd0) || (col == col_mask);
    endfunction

endpackage

// File: rtl/lbp_sp_ram.sv
// rtl/lbp_sp_ram.sv - single write port RAM with registered, holdable, zero-forcible read port
module lbp_sp_ram #(
    parameter int AW = 14,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic          rzero,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Array contents survive reset; only the write strobe updates them.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register clears on reset and otherwise holds until the next read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= rzero ? '0 : mem[raddr];
        end
    end

endmodule

// File: rtl/lbp_host_mem.sv
// rtl/lbp_host_mem.sv - host image/result memory with load, serve and readback phases for the LBP engine
module lbp_host_mem
    import lbp_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int AW    = 14,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_valid,
    input  logic [AW-1:0] load_addr,
    input  logic [DW-1:0] load_data,
    input  logic          load_done,
    output logic          gray_ready,
    input  logic          gray_req,
    input  logic [AW-1:0] gray_addr,
    output logic [DW-1:0] gray_data,
    input  logic          lbp_valid,
    input  logic [AW-1:0] lbp_addr,
    input  logic [DW-1:0] lbp_data,
    input  logic          finish,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          done,
    output logic [AW-1:0] wr_count,
    output logic          err
);

    localparam int          W_LOG2  = $clog2(IMG_W);
    localparam logic [31:0] NPIX    = 32'(IMG_W * IMG_H);
    localparam logic [31:0] EXP_CNT = 32'((IMG_W - 2) * (IMG_H - 2));

    state_t        state;
    state_t        state_nxt;
    logic          load_in;
    logic          gray_in;
    logic          lbp_in;
    logic          rd_in;
    logic          lbp_ok;
    logic          rd_zero;
    logic          lbp_accept;
    logic [AW-1:0] wr_count_nxt;
    logic          img_we;
    logic          res_we;
    logic          gray_re;
    logic          rd_re;
    logic          err_set;

    assign load_in = (32'(load_addr) < NPIX);
    assign gray_in = (32'(gray_addr) < NPIX);
    assign lbp_in  = (32'(lbp_addr) < NPIX);
    assign rd_in   = (32'(rd_addr) < NPIX);
    assign lbp_ok  = lbp_in && !is_border(32'(lbp_addr), W_LOG2, IMG_H);
    assign rd_zero = !rd_in || is_border(32'(rd_addr), W_LOG2, IMG_H);

    // Accepted result writes, and the count including this cycle's write for the finish check.
    assign lbp_accept   = (state == ST_SERVE) && lbp_valid && lbp_ok;
    assign wr_count_nxt = (lbp_accept && (wr_count != {AW{1'b1}})) ? wr_count + 1'b1 : wr_count;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: load_done leaves LOAD, finish leaves SERVE, DONE holds until reset.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD:  if (load_done) state_nxt = ST_SERVE;
            ST_SERVE: if (finish)    state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_DONE;
            default:  state_nxt = ST_LOAD;
        endcase
    end

    // Per-state memory strobes and protocol error detection.
    always_comb begin
        img_we  = 1'b0;
        res_we  = 1'b0;
        gray_re = 1'b0;
        rd_re   = 1'b0;
        err_set = 1'b0;
        case (state)
            ST_LOAD: begin
                if (load_valid) begin
                    if (load_in) img_we  = 1'b1;
                    else         err_set = 1'b1;
                end
                if (lbp_valid || finish) err_set = 1'b1;
            end
            ST_SERVE: begin
                gray_re = gray_req;
                if (gray_req && !gray_in) err_set = 1'b1;
                if (lbp_valid) begin
                    if (lbp_ok) res_we  = 1'b1;
                    else        err_set = 1'b1;
                end
                if (finish && (32'(wr_count_nxt) != EXP_CNT)) err_set = 1'b1;
            end
            ST_DONE: begin
                rd_re = rd_req;
                if (rd_req && !rd_in) err_set = 1'b1;
                if (lbp_valid)        err_set = 1'b1;
            end
            default: ;
        endcase
    end

    // Registered status flags follow the upcoming state so they settle with the transition.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gray_ready <= 1'b0;
            done       <= 1'b0;
            rd_valid   <= 1'b0;
            wr_count   <= '0;
            err        <= 1'b0;
        end else begin
            gray_ready <= (state_nxt == ST_SERVE);
            done       <= (state_nxt == ST_DONE);
            rd_valid   <= rd_re;
            wr_count   <= wr_count_nxt;
            if (err_set) err <= 1'b1;
        end
    end

    lbp_sp_ram #(.AW(AW), .DW(DW)) u_img (
        .clk   (clk),
        .reset (reset),
        .we    (img_we),
        .waddr (load_addr),
        .wdata (load_data),
        .re    (gray_re),
        .rzero (!gray_in),
        .raddr (gray_addr),
        .rdata (gray_data)
    );

    lbp_sp_ram #(.AW(AW), .DW(DW)) u_res (
        .clk   (clk),
        .reset (reset),
        .we    (res_we),
        .waddr (lbp_addr),
        .wdata (lbp_data),
        .re    (rd_re),
        .rzero (rd_zero),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_lbp_host_mem.sv
// tb/tb_lbp_host_mem.sv - scoreboard bench for lbp_host_mem against a behavioural model
module tb_lbp_host_mem;

    localparam int AW   = 14;
    localparam int DW   = 8;
    localparam int W    = 128;
    localparam int H    = 128;
    localparam int NPIX = W * H;
    localparam int EXPW = (W - 2) * (H - 2);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          load_valid = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [DW-1:0] load_data = '0;
    logic          load_done = 1'b0;
    logic          gray_ready;
    logic          gray_req = 1'b0;
    logic [AW-1:0] gray_addr = '0;
    logic [DW-1:0] gray_data;
    logic          lbp_valid = 1'b0;
    logic [AW-1:0] lbp_addr = '0;
    logic [DW-1:0] lbp_data = '0;
    logic          finish = 1'b0;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          done;
    logic [AW-1:0] wr_count;
    logic          err;

    lbp_host_mem #(.IMG_W(W), .IMG_H(H), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .load_done  (load_done),
        .gray_ready (gray_ready),
        .gray_req   (gray_req),
        .gray_addr  (gray_addr),
        .gray_data  (gray_data),
        .lbp_valid  (lbp_valid),
        .lbp_addr   (lbp_addr),
        .lbp_data   (lbp_data),
        .finish     (finish),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .done       (done),
        .wr_count   (wr_count),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;
    int q_gray[$];
    int q_rd[$];

    // Model: phase 0 = loading, 1 = serving, 2 = results done.
    int m_img [NPIX];
    int m_res [NPIX];
    int m_phase = 0;
    int m_wr = 0;
    int m_err = 0;
    int m_gh = 0;

    function automatic bit m_border(input int a);
        int row;
        int col;
        row = a / W;
        col = a % W;
        return (row == 0) || (row == H - 1) || (col == 0) || (col == W - 1);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // One clock of stimulus; the model decides the outcome and queues expected read data.
    task automatic cyc(input bit lv = 0, input int la = 0, input int ld = 0, input bit ldn = 0,
                       input bit gr = 0, input int ga = 0, input bit wv = 0, input int wa = 0,
                       input int wd = 0, input bit fin = 0, input bit rr = 0, input int ra = 0);
        int pre;
        pre = m_phase;
        if (gr) begin
            if (pre == 1) m_gh = (ga < NPIX) ? m_img[ga] : 0;
            q_gray.push_back(m_gh);
        end
        if (rr && pre == 2) q_rd.push_back((ra < NPIX && !m_border(ra)) ? m_res[ra] : 0);
        if (pre == 0) begin
            if (lv) m_img[la] = ld & 255;
            if (wv || fin) m_err = 1;
            if (ldn) m_phase = 1;
        end else if (pre == 1) begin
            if (wv) begin
                if (wa >= NPIX || m_border(wa)) m_err = 1;
                else begin
                    m_res[wa] = wd & 255;
                    if (m_wr < (1 << AW) - 1) m_wr++;
                end
            end
            if (fin) begin
                if (m_wr != EXPW) m_err = 1;
                m_phase = 2;
            end
        end else begin
            if (wv) m_err = 1;
        end
        load_valid = lv;  load_addr = la[AW-1:0]; load_data = ld[DW-1:0]; load_done = ldn;
        gray_req   = gr;  gray_addr = ga[AW-1:0];
        lbp_valid  = wv;  lbp_addr  = wa[AW-1:0]; lbp_data  = wd[DW-1:0];
        finish     = fin; rd_req    = rr;         rd_addr   = ra[AW-1:0];
        @(posedge clk);
        #1;
        load_valid = 0; load_done = 0; gray_req = 0; lbp_valid = 0; finish = 0; rd_req = 0;
    endtask

    task automatic do_reset();
        cyc();
        reset = 1'b1;
        m_phase = 0; m_wr = 0; m_err = 0; m_gh = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic chk_status(input string tag);
        chk({tag, " gray_ready"}, int'(gray_ready), (m_phase == 1) ? 1 : 0);
        chk({tag, " done"}, int'(done), (m_phase == 2) ? 1 : 0);
        chk({tag, " wr_count"}, int'(wr_count), m_wr);
        chk({tag, " err"}, int'(err), m_err);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " gray_data"}, int'(gray_data), 0);
        chk({tag, " rd_data"}, int'(rd_data), 0);
        chk({tag, " rd_valid"}, int'(rd_valid), 0);
        chk({tag, " gray_ready"}, int'(gray_ready), 0);
        chk({tag, " done"}, int'(done), 0);
        chk({tag, " wr_count"}, int'(wr_count), 0);
        chk({tag, " err"}, int'(err), 0);
    endtask

    task automatic enter_serve();
        int k;
        cyc(.ldn(1));
        k = 0;
        while (gray_ready !== 1'b1 && k < 2) begin
            cyc();
            k++;
        end
        chk("gray_ready after load_done", int'(gray_ready), 1);
    endtask

    // Monitor: gray_data is checked the cycle after a request, rd_data whenever rd_valid shows.
    initial begin
        bit g_d;
        int e;
        forever begin
            @(posedge clk);
            g_d = gray_req;
            @(negedge clk);
            if (g_d) begin
                if (q_gray.size() == 0) chk("gray scoreboard underflow", 1, 0);
                else begin
                    e = q_gray.pop_front();
                    chk("gray_data", int'(gray_data), e);
                end
            end
            if (rd_valid) begin
                if (q_rd.size() == 0) chk("unexpected rd_valid", 1, 0);
                else begin
                    e = q_rd.pop_front();
                    chk("rd_data", int'(rd_data), e);
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_reset_vals("reset");

        // Requests while loading are ignored.
        cyc(.gr(1), .ga(5));
        cyc(.rr(1), .ra(129));
        cyc();

        // Load img[a] = a[7:0]; load_done rides on the last write.
        for (int a = 0; a < NPIX; a++) cyc(.lv(1), .la(a), .ld(a & 255), .ldn(a == NPIX - 1));
        begin
            int k;
            k = 0;
            while (gray_ready !== 1'b1 && k < 2) begin
                cyc();
                k++;
            end
            chk("gray_ready after load", int'(gray_ready), 1);
        end
        cyc(.gr(1), .ga(129));
        cyc(.gr(1), .ga(130));
        cyc(.gr(1), .ga(16383));
        for (int i = 0; i < 20; i++) cyc(.gr(1), .ga(int'($urandom_range(0, NPIX - 1))));
        cyc();
        chk("img 129", m_img[129], 8'h81);

        // Single result write, early finish: count mismatch flags err.
        cyc(.wv(1), .wa(129), .wd(8'hA5));
        chk_status("one write");
        cyc(.fin(1));
        chk_status("early finish");
        cyc(.rr(1), .ra(129));
        cyc(.rr(1), .ra(0));
        cyc();
        chk("early finish err", int'(err), 1);

        // finish while loading, reset mid-SERVE, then a dropped border write.
        do_reset();
        chk_reset_vals("reset 2");
        cyc(.fin(1));
        chk_status("finish in load");
        enter_serve();
        for (int i = 0; i < 5; i++) cyc(.gr(1), .ga(int'($urandom_range(0, NPIX - 1))));
        do_reset();
        chk_reset_vals("mid serve reset");
        cyc(.gr(1), .ga(129));
        cyc(.gr(1), .ga(300));
        cyc();
        chk("gray_data after reset", int'(gray_data), 0);
        enter_serve();
        cyc(.wv(1), .wa(128), .wd(8'h55));
        chk_status("border write");
        cyc(.fin(1));
        cyc(.rr(1), .ra(128));
        cyc();

        // Full interior run with background gray reads.
        do_reset();
        enter_serve();
        for (int r = 1; r < H - 1; r++) begin
            for (int c = 1; c < W - 1; c++) begin
                int a;
                a = r * W + c;
                cyc(.wv(1), .wa(a), .wd(a & 255),
                    .gr(1'($urandom_range(0, 1))), .ga(int'($urandom_range(0, NPIX - 1))));
            end
        end
        chk("full wr_count", int'(wr_count), 15876);
        cyc(.fin(1));
        chk_status("full done");
        chk("full err", int'(err), 0);
        cyc(.rr(1), .ra(0));
        cyc(.rr(1), .ra(127));
        cyc(.rr(1), .ra(16254));
        for (int i = 0; i < 30; i++) cyc(.rr(1), .ra(int'($urandom_range(0, NPIX - 1))));
        cyc();
        chk("res 16254", m_res[16254], 8'h7E);

        // Duplicate write counts twice; write with finish in the same cycle is kept.
        do_reset();
        enter_serve();
        cyc(.wv(1), .wa(300), .wd(int'($urandom_range(0, 255))));
        cyc(.wv(1), .wa(300), .wd(int'($urandom_range(0, 255))));
        chk("duplicate wr_count", int'(wr_count), 2);
        cyc(.wv(1), .wa(200), .wd(8'h3C), .fin(1));
        chk_status("write with finish");
        cyc(.wv(1), .wa(400), .wd(8'h11));
        chk_status("write in done");
        cyc(.rr(1), .ra(200));
        cyc(.rr(1), .ra(300));
        cyc(.rr(1), .ra(400));
        repeat (3) cyc();

        chk("gray queue drained", q_gray.size(), 0);
        chk("rd queue drained", q_rd.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
